// File: rtl/alu_writeback.sv
// Writeback/status stage behind the 16-bit ALU: architectural flags, sticky overflow,
// a 2-entry register-write queue with valid/ready drain, branch condition and forwarding lookup.
module alu_writeback #(
  parameter int         DATA_W = 16,
  parameter int         ADDR_W = 3,
  parameter logic [4:0] OP_CMP = 5'd12,
  parameter logic [4:0] OP_TST = 5'd13,
  parameter logic [4:0] OP_NOP = 5'd31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [DATA_W-1:0] in_result,
  input  logic [3:0]        in_flags,
  input  logic              in_wr_en,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags_q,
  output logic              ovf_sticky,
  input  logic              clr_sticky,
  input  logic [2:0]        cond_sel,
  output logic              cond_true,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  logic [1:0]        count_q, count_d;
  logic              head_q, head_d;
  logic              tail_q, tail_d;
  logic [3:0]        flags_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] addr_q [2];
  logic [DATA_W-1:0] data_q [2];

  logic accept_s, writes_s, push_s, pop_s;
  logic young_s;

  assign in_ready   = (count_q != 2'd2);
  assign wb_valid   = (count_q != 2'd0);
  assign wb_addr    = addr_q[head_q];
  assign wb_data    = data_q[head_q];
  assign ovf_sticky = ovf_q;

  assign accept_s = in_valid && in_ready;
  assign writes_s = !((in_opcode == OP_CMP) || (in_opcode == OP_TST) || (in_opcode == OP_NOP));
  assign push_s   = accept_s && in_wr_en && writes_s;
  assign pop_s    = wb_valid && wb_ready;
  assign young_s  = ~tail_q;

  // Next-state for queue pointers, occupancy, flags and sticky overflow
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    flags_d = flags_q;
    ovf_d   = ovf_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (pop_s) begin
      head_d = ~head_q;
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d = ~tail_q;
    end else begin
      tail_d = tail_q;
    end
    if (accept_s && (in_opcode != OP_NOP)) begin
      flags_d = in_flags;
    end else begin
      flags_d = flags_q;
    end
    // A new overflow outranks a same-cycle clear
    if (accept_s && in_flags[0]) begin
      ovf_d = 1'b1;
    end else if (clr_sticky) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers and queue slot storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 2'd0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      flags_q   <= 4'b0000;
      ovf_q     <= 1'b0;
      addr_q[0] <= {ADDR_W{1'b0}};
      addr_q[1] <= {ADDR_W{1'b0}};
      data_q[0] <= {DATA_W{1'b0}};
      data_q[1] <= {DATA_W{1'b0}};
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      if (push_s) begin
        addr_q[tail_q] <= in_dest;
        data_q[tail_q] <= in_result;
      end
    end
  end

  // Branch condition decode over architectural flags {Z,N,C,O}
  always_comb begin
    cond_true = 1'b0;
    case (cond_sel)
      3'd0:    cond_true = 1'b1;
      3'd1:    cond_true = flags_q[3];
      3'd2:    cond_true = !flags_q[3];
      3'd3:    cond_true = flags_q[2] ^ flags_q[0];
      3'd4:    cond_true = !(flags_q[2] ^ flags_q[0]);
      3'd5:    cond_true = flags_q[1];
      3'd6:    cond_true = flags_q[0];
      default: cond_true = 1'b0;
    endcase
  end

  // Forwarding: the slot behind the tail is the youngest and is valid whenever the queue is non-empty
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = {DATA_W{1'b0}};
    if ((count_q != 2'd0) && (addr_q[young_s] == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = data_q[young_s];
    end else if ((count_q == 2'd2) && (addr_q[head_q] == fwd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = data_q[head_q];
    end else begin
      fwd_hit  = 1'b0;
      fwd_data = {DATA_W{1'b0}};
    end
  end

endmodule
